midi_rx: RTL and testbench

//  MIDI IN receiver: the receive end of the MIDI link driven by the AY port-A bit-2 TX line.

---
 rtl/midi_pkg.sv | 40 ++++
 rtl/midi_uart_rx.sv | 99 +++++++++
 rtl/midi_rx.sv | 132 +++++++++++++
 tb/tb_midi_rx.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/midi_pkg.sv
// Shared MIDI receiver constants: bit timing, status-byte classes and the
// number of data bytes each status byte expects.
package midi_pkg;

  localparam int BIT_TICKS  = 112;
  localparam int HALF_TICKS = 56;

  localparam logic [2:0] CHAN2    = 3'd0;
  localparam logic [2:0] CHAN1    = 3'd1;
  localparam logic [2:0] SYSCOM   = 3'd2;
  localparam logic [2:0] SYSEX    = 3'd3;
  localparam logic [2:0] REALTIME = 3'd4;
  localparam logic [2:0] DATABYTE = 3'd5;

  typedef enum logic [1:0] {U_IDLE, U_START, U_DATA, U_STOP} uart_state_t;

  function automatic logic [2:0] status_class(input logic [7:0] b);
    logic [2:0] cls;
    if (!b[7])                cls = DATABYTE;
    else if (b >= 8'hF8)      cls = REALTIME;
    else if (b == 8'hF0)      cls = SYSEX;
    else if (b >= 8'hF1)      cls = SYSCOM;
    else if (b[6:5] == 2'b10) cls = CHAN1;
    else                      cls = CHAN2;
    return cls;
  endfunction

  // Zero means the status byte never collects data (it is emitted or dropped at once).
  function automatic logic [1:0] data_count(input logic [7:0] b);
    logic [1:0] n;
    case (status_class(b))
      CHAN2:   n = 2'd2;
      CHAN1:   n = 2'd1;
      SYSCOM:  n = (b == 8'hF2) ? 2'd2 : ((b == 8'hF1 || b == 8'hF3) ? 2'd1 : 2'd0);
      default: n = 2'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/midi_uart_rx.sv
// 8N1 serial deserialiser for the MIDI input; timing advances only on clk35en.
module midi_uart_rx #(
  parameter int BIT_TICKS  = midi_pkg::BIT_TICKS,
  parameter int HALF_TICKS = midi_pkg::HALF_TICKS
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clk35en,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] rx_byte,
  output logic       framing_err
);
  import midi_pkg::*;

  localparam int TW = $clog2(BIT_TICKS);

  uart_state_t   state;
  logic          rx_p0, rx_p1, rx_p2;
  logic [TW-1:0] tick;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          tick_bit, tick_half;

  assign tick_bit  = (tick == TW'(BIT_TICKS - 1));
  assign tick_half = (tick == TW'(HALF_TICKS - 1));
  assign rx_byte   = shreg;

  // Stage p0/p1: synchroniser, preset to the idle level
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_p0 <= 1'b1;
      rx_p1 <= 1'b1;
    end else begin
      rx_p0 <= rx;
      rx_p1 <= rx_p0;
    end
  end

  // Stage p2: previous enabled sample, used for start-edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= U_IDLE;
      tick        <= '0;
      bit_cnt     <= '0;
      rx_p2       <= 1'b1;
      byte_valid  <= 1'b0;
      framing_err <= 1'b0;
    end else begin
      byte_valid  <= 1'b0;
      framing_err <= 1'b0;
      if (clk35en) begin
        rx_p2 <= rx_p1;
        case (state)
          U_IDLE: begin
            if (rx_p2 && !rx_p1) begin
              state <= U_START;
              tick  <= '0;
            end
          end
          U_START: begin
            if (tick_half) begin
              tick    <= '0;
              bit_cnt <= '0;
              state   <= rx_p1 ? U_IDLE : U_DATA;
            end else begin
              tick <= tick + 1'b1;
            end
          end
          U_DATA: begin
            if (tick_bit) begin
              tick    <= '0;
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) state <= U_STOP;
            end else begin
              tick <= tick + 1'b1;
            end
          end
          U_STOP: begin
            if (tick_bit) begin
              tick  <= '0;
              state <= U_IDLE;
              if (rx_p1) byte_valid  <= 1'b1;
              else       framing_err <= 1'b1;
            end else begin
              tick <= tick + 1'b1;
            end
          end
          default: state <= U_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clk35en && state == U_DATA && tick_bit) shreg <= {rx_p1, shreg[7:1]};
  end

endmodule

// File: rtl/midi_rx.sv
// MIDI IN receiver: UART front end plus message assembler with running status,
// real-time interleave and SysEx skipping, feeding a valid/ready output register.
module midi_rx #(
  parameter int BIT_TICKS  = midi_pkg::BIT_TICKS,
  parameter int HALF_TICKS = midi_pkg::HALF_TICKS
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clk35en,
  input  logic       rx,
  input  logic       msg_ready,
  input  logic       ovr_clr,
  output logic       msg_valid,
  output logic [7:0] msg_status,
  output logic [7:0] msg_data1,
  output logic [7:0] msg_data2,
  output logic [1:0] msg_len,
  output logic       overrun,
  output logic       framing_err
);
  import midi_pkg::*;

  logic       byte_valid;
  logic [7:0] rx_byte;

  midi_uart_rx #(.BIT_TICKS(BIT_TICKS), .HALF_TICKS(HALF_TICKS)) u_uart (
    .clk         (clk),
    .reset       (reset),
    .clk35en     (clk35en),
    .rx          (rx),
    .byte_valid  (byte_valid),
    .rx_byte     (rx_byte),
    .framing_err (framing_err)
  );

  // act_status[7]==0 means no status is active (no running status)
  logic [7:0] act_status;
  logic [1:0] act_need;
  logic [1:0] got_cnt;
  logic [7:0] d1_hold;
  logic       in_sysex;

  logic       emit;
  logic [7:0] em_status, em_d1, em_d2;
  logic [1:0] em_len;
  logic [2:0] cls;

  always_comb begin
    cls       = status_class(rx_byte);
    emit      = 1'b0;
    em_status = rx_byte;
    em_d1     = 8'h00;
    em_d2     = 8'h00;
    em_len    = 2'd0;
    if (byte_valid) begin
      if (cls == REALTIME || rx_byte == 8'hF6) begin
        emit = 1'b1;
      end else if (cls == DATABYTE && !in_sysex && act_status[7] &&
                   (2'(got_cnt + 2'd1) == act_need)) begin
        emit      = 1'b1;
        em_status = act_status;
        em_len    = act_need;
        if (act_need == 2'd1) begin
          em_d1 = rx_byte;
        end else begin
          em_d1 = d1_hold;
          em_d2 = rx_byte;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      act_status <= 8'h00;
      act_need   <= 2'd0;
      got_cnt    <= 2'd0;
      in_sysex   <= 1'b0;
    end else if (framing_err) begin
      got_cnt <= 2'd0;
    end else if (byte_valid) begin
      case (cls)
        REALTIME: ;
        DATABYTE: begin
          if (!in_sysex && act_status[7]) begin
            if (emit) begin
              got_cnt <= 2'd0;
              // system common messages do not establish running status
              if (act_status[7:4] == 4'hF) act_status <= 8'h00;
            end else begin
              got_cnt <= got_cnt + 2'd1;
            end
          end
        end
        default: begin
          in_sysex   <= (cls == SYSEX);
          got_cnt    <= 2'd0;
          act_need   <= data_count(rx_byte);
          act_status <= (data_count(rx_byte) != 2'd0) ? rx_byte : 8'h00;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (byte_valid && !rx_byte[7]) d1_hold <= rx_byte;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      msg_valid  <= 1'b0;
      msg_status <= 8'h00;
      msg_data1  <= 8'h00;
      msg_data2  <= 8'h00;
      msg_len    <= 2'd0;
      overrun    <= 1'b0;
    end else begin
      if (emit && (!msg_valid || msg_ready)) begin
        msg_valid  <= 1'b1;
        msg_status <= em_status;
        msg_data1  <= em_d1;
        msg_data2  <= em_d2;
        msg_len    <= em_len;
      end else if (msg_valid && msg_ready) begin
        msg_valid <= 1'b0;
      end
      if (emit && msg_valid && !msg_ready) overrun <= 1'b1;
      else if (ovr_clr)                    overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_midi_rx.sv
// Self-checking bench for midi_rx: serial frames in, assembled messages compared
// against a queue filled by a byte-level MIDI parsing model.
module tb_midi_rx;
  import midi_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       clk35en = 1'b0;
  logic       rx = 1'b1;
  logic       msg_ready = 1'b0;
  logic       ovr_clr = 1'b0;
  logic       msg_valid;
  logic [7:0] msg_status, msg_data1, msg_data2;
  logic [1:0] msg_len;
  logic       overrun;
  logic       framing_err;

  midi_rx dut (
    .clk         (clk),
    .reset       (reset),
    .clk35en     (clk35en),
    .rx          (rx),
    .msg_ready   (msg_ready),
    .ovr_clr     (ovr_clr),
    .msg_valid   (msg_valid),
    .msg_status  (msg_status),
    .msg_data1   (msg_data1),
    .msg_data2   (msg_data2),
    .msg_len     (msg_len),
    .overrun     (overrun),
    .framing_err (framing_err)
  );

  always #5 clk = ~clk;

  // Enable high on most clocks, dropping one in 32 so the gating is exercised
  initial begin
    forever begin
      for (int k = 0; k < 32; k++) begin
        @(negedge clk);
        clk35en = (k != 0);
      end
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic [7:0] st;
    logic [7:0] d1;
    logic [7:0] d2;
    logic [1:0] len;
  } msg_t;

  msg_t       exp_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         fe_cnt = 0;

  logic [7:0] m_act;
  int         m_need;
  logic [7:0] m_buf[$];
  bit         m_sysex;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_act   = 8'h00;
    m_need  = 0;
    m_sysex = 1'b0;
    m_buf.delete();
    exp_q.delete();
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (b >= 8'hF8) begin
      exp_q.push_back({b, 8'h00, 8'h00, 2'd0});
      return;
    end
    if (b[7]) begin
      m_sysex = (b == 8'hF0);
      m_buf.delete();
      if (b < 8'hF0) begin
        m_act  = b;
        m_need = (b >= 8'hC0 && b < 8'hE0) ? 1 : 2;
      end else begin
        m_act  = 8'h00;
        m_need = 0;
        if (b == 8'hF1 || b == 8'hF3) begin m_act = b; m_need = 1; end
        if (b == 8'hF2)               begin m_act = b; m_need = 2; end
        if (b == 8'hF6) exp_q.push_back({b, 8'h00, 8'h00, 2'd0});
      end
      return;
    end
    if (m_sysex || m_act == 8'h00) return;
    m_buf.push_back(b);
    if (m_buf.size() == m_need) begin
      exp_q.push_back({m_act, m_buf[0], (m_need == 2) ? m_buf[1] : 8'h00, 2'(m_need)});
      m_buf.delete();
      if (m_act >= 8'hF0) m_act = 8'h00;
    end
  endtask

  always @(negedge clk) begin : mon
    msg_t e;
    if (framing_err) fe_cnt++;
    if (!reset && msg_valid && msg_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_msg", {22'd0, msg_status, msg_len}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("msg_status", msg_status, e.st);
        chk("msg_data1", msg_data1, e.d1);
        chk("msg_data2", msg_data2, e.d2);
        chk("msg_len", msg_len, e.len);
      end
    end
  end

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      do @(posedge clk); while (!clk35en);
    end
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit chk_pre);
    if (stop_ok) model_byte(b);
    else         m_buf.delete();
    rx = 1'b1; ticks(4);
    rx = 1'b0; ticks(BIT_TICKS);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      ticks(BIT_TICKS);
    end
    if (chk_pre) chk("no_early_msg", msg_valid, 0);
    rx = stop_ok; ticks(BIT_TICKS);
    rx = 1'b1;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 4000 && (exp_q.size() != 0 || msg_valid); i++) @(negedge clk);
    @(negedge clk);
    chk({tag, "_left"}, exp_q.size(), 0);
    chk({tag, "_vld"}, msg_valid, 0);
  endtask

  initial begin
    int         fe0;
    logic [7:0] b;
    model_reset();
    repeat (4) @(posedge clk);
    #1;
    chk("rst_vld", msg_valid, 0);
    chk("rst_status", msg_status, 0);
    chk("rst_d1", msg_data1, 0);
    chk("rst_d2", msg_data2, 0);
    chk("rst_len", msg_len, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_fe", framing_err, 0);
    reset = 1'b0;
    ticks(20);

    // basic note-on, held in the register until accepted
    send_frame(8'h90, 1, 0);
    send_frame(8'h3C, 1, 0);
    chk("t1_mid_vld", msg_valid, 0);
    send_frame(8'h64, 1, 1);
    chk("t1_vld", msg_valid, 1);
    chk("t1_status", msg_status, 8'h90);
    chk("t1_d1", msg_data1, 8'h3C);
    chk("t1_d2", msg_data2, 8'h64);
    chk("t1_len", msg_len, 2);
    msg_ready = 1'b1;
    drain("t1");

    // running status
    send_frame(8'h90, 1, 0); send_frame(8'h3C, 1, 0); send_frame(8'h64, 1, 0);
    send_frame(8'h3E, 1, 0); send_frame(8'h00, 1, 0);
    drain("t2");

    // real-time interleave
    send_frame(8'h90, 1, 0); send_frame(8'h3C, 1, 0);
    send_frame(8'hF8, 1, 0); send_frame(8'h64, 1, 0);
    drain("t3");

    // SysEx skipped, then program change
    send_frame(8'hF0, 1, 0); send_frame(8'h7E, 1, 0); send_frame(8'h00, 1, 0);
    send_frame(8'hF7, 1, 0); send_frame(8'hC5, 1, 0); send_frame(8'h12, 1, 0);
    drain("t4");

    // framing error on second byte
    fe0 = fe_cnt;
    send_frame(8'h90, 1, 0); send_frame(8'h3C, 0, 0); send_frame(8'h64, 1, 0);
    chk("t5_fe", fe_cnt - fe0, 1);
    send_frame(8'h90, 1, 0); send_frame(8'h40, 1, 0); send_frame(8'h7F, 1, 0);
    drain("t5");

    // overrun: second message dropped while the first is held
    msg_ready = 1'b0;
    send_frame(8'h90, 1, 0); send_frame(8'h3C, 1, 0); send_frame(8'h64, 1, 0);
    send_frame(8'h90, 1, 0); send_frame(8'h3E, 1, 0); send_frame(8'h00, 1, 0);
    void'(exp_q.pop_back());
    chk("t6_ovr", overrun, 1);
    chk("t6_vld", msg_valid, 1);
    chk("t6_status", msg_status, 8'h90);
    chk("t6_d1", msg_data1, 8'h3C);
    chk("t6_d2", msg_data2, 8'h64);
    ovr_clr = 1'b1;
    @(posedge clk); #1;
    ovr_clr = 1'b0;
    chk("t6_ovr_clr", overrun, 0);
    msg_ready = 1'b1;
    drain("t6");

    // short low glitch on idle line
    fe0 = fe_cnt;
    rx = 1'b0; ticks(40);
    rx = 1'b1; ticks(300);
    chk("t7_fe", fe_cnt - fe0, 0);
    chk("t7_vld", msg_valid, 0);

    // reset in the middle of a data bit
    msg_ready = 1'b0;
    send_frame(8'h90, 1, 0); send_frame(8'h3C, 1, 0); send_frame(8'h64, 1, 0);
    chk("t8_pre_vld", msg_valid, 1);
    fe0 = fe_cnt;
    rx = 1'b1; ticks(4);
    rx = 1'b0; ticks(BIT_TICKS);
    rx = 1'b1; ticks(BIT_TICKS + 30);
    reset = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    chk("t8_rst_vld", msg_valid, 0);
    chk("t8_rst_status", msg_status, 0);
    chk("t8_rst_d1", msg_data1, 0);
    chk("t8_rst_len", msg_len, 0);
    model_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    ticks(2 * BIT_TICKS);
    chk("t8_fe", fe_cnt - fe0, 0);
    msg_ready = 1'b1;
    send_frame(8'hC5, 1, 0); send_frame(8'h12, 1, 0);
    drain("t8");

    // randomized byte stream with occasional framing errors
    for (int n = 0; n < 14; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: b = 8'($urandom_range(0, 127));
        5, 6:          b = 8'($urandom_range(128, 239));
        7:             b = 8'($urandom_range(240, 247));
        8:             b = 8'($urandom_range(248, 255));
        default:       b = ($urandom_range(0, 1) != 0) ? 8'hC5 : 8'h90;
      endcase
      send_frame(b, $urandom_range(0, 11) != 0, 0);
    end
    drain("t9");
    chk("t9_ovr", overrun, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
